// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO.
// A byte is popped when the line is idle and sent LSB first with one stop bit.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done,
    output logic [4:0] o_Fifo_Count
);

    localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH    = 5'(FIFO_DEPTH);
    localparam logic [13:0] BIT_LAST = 14'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]         count_q, count_d;
    logic [13:0]        clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               serial_q, serial_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               wr_en;
    logic               pop;

    // Ready comes from the registered count, so a write while full is dropped
    // even when a pop happens in the same cycle.
    assign wr_en = i_Tx_DV && (count_q < DEPTH);

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // Outputs are computed for the next state so the line and active flag
    // come straight from flops and align with the state register.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = 1'b1;
        active_d  = 1'b0;
        done_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 5'd0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = 3'd0;
                    clk_cnt_d = 14'd0;
                    state_d   = S_START;
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                end
            end
            S_START: begin
                active_d = 1'b1;
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 14'd0;
                    state_d   = S_DATA;
                    serial_d  = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 14'd1;
                    serial_d  = 1'b0;
                end
            end
            S_DATA: begin
                active_d = 1'b1;
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 14'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        serial_d  = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 14'd1;
                    serial_d  = shift_q[0];
                end
            end
            S_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 14'd0;
                    state_d   = S_CLEANUP;
                    done_d    = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 14'd1;
                    active_d  = 1'b1;
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    assign o_Tx_Ready   = (count_q < DEPTH);
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Done    = done_q;
    assign o_Fifo_Count = count_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (legal range 4..16383).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning number of byte entries in the transmit FIFO (power of 2, 2..16).
REQ-003 i_Clock  input  1  single system clock; all logic on its rising edge.
REQ-004 i_Reset  input  1  reset, asynchronous, active-high.
REQ-005 i_Tx_DV  input  1  write strobe for i_Tx_Byte, one byte per high cycle.
REQ-006 i_Tx_Byte  input  8  byte to enqueue.
REQ-007 o_Tx_Ready  output  1  FIFO not full; write accepted this cycle.
REQ-008 o_Tx_Serial  output  1  serial line, idle high, 8N1, LSB first.
REQ-009 o_Tx_Active  output  1  high while a frame (start/data/stop) is on the line.
REQ-010 o_Tx_Done  output  1  one-cycle pulse after each frame's stop bit.
REQ-011 o_Fifo_Count  output  5  number of bytes currently queued (0..FIFO_DEPTH).

Function
REQ-012 Write SHALL occur when i_Tx_DV=1 and o_Tx_Ready=1; byte stored at write pointer, pointer increments modulo FIFO_DEPTH.
REQ-013 i_Tx_DV while o_Tx_Ready=0 SHALL be dropped with no state change, even if a pop occurs the same cycle.
REQ-014 o_Tx_Ready SHALL equal (o_Fifo_Count < FIFO_DEPTH), from registered count.
REQ-015 Simultaneous accepted write and pop SHALL leave o_Fifo_Count unchanged.
REQ-016 FSM states: IDLE, START, DATA, STOP, CLEANUP; encoding free, illegal states SHALL return to IDLE.
REQ-017 IDLE: line high; if o_Fifo_Count>0, pop head byte into shift register, bit index=0, counter=0, go START next cycle; else stay.
REQ-018 START: o_Tx_Serial=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: o_Tx_Serial=byte[bit index] for CLKS_PER_BIT cycles per bit, index 0..7; after bit 7 go STOP.
REQ-020 STOP: o_Tx_Serial=1 for exactly CLKS_PER_BIT cycles, then CLEANUP.
REQ-021 CLEANUP: lasts one cycle, o_Tx_Done=1, line high, then IDLE.
REQ-022 o_Tx_Serial and o_Tx_Active SHALL be registered outputs (no combinational path from inputs).
REQ-023 o_Tx_Active SHALL be 1 exactly in START, DATA, STOP.
REQ-024 Back-to-back frames: line high exactly CLKS_PER_BIT+2 cycles between last data bit end and next start bit (stop + CLEANUP + IDLE).
REQ-025 Bit-period counter SHALL be 14 bits, count 0..CLKS_PER_BIT-1, never wrap mid-bit.
REQ-026 Byte popped SHALL be captured at pop; later FIFO writes SHALL not alter the frame in flight.

Reset
REQ-027 While i_Reset=1: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, pointers=0, state IDLE.
REQ-028 Reset mid-frame SHALL abort the frame immediately (line high asynchronously) and discard queued bytes.
REQ-029 After release, first write SHALL be accepted on the first rising edge with i_Reset=0.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-030 Write 0x55 once -> after 1 IDLE cycle, line: 0 x4, then 1,0,1,0,1,0,1,0 each x4, 1 x4; o_Tx_Done pulse 1 cycle; o_Tx_Active high 40 cycles.
REQ-031 Write 0x00,0xFF,0xA5 on consecutive cycles -> three frames in order, 6 high cycles between data end and next start, count 3->...->0.
REQ-032 Write 9 bytes in 9 cycles while idle with no pop yet -> first pop frees slot; verify dropped/accepted per REQ-013/015, final count and transmitted sequence match accepted bytes only.
REQ-033 Fill to 8 while transmitting -> o_Tx_Ready=0, extra write 0x3C not transmitted; o_Tx_Ready returns 1 on next pop.
REQ-034 Assert i_Reset during DATA bit 3 of 0xC3 -> o_Tx_Serial=1 same cycle, count 0, no o_Tx_Done, new write 0x81 transmits correctly.
REQ-035 Write 0x12 during STOP of previous frame -> queued, starts after CLEANUP+IDLE with no gap beyond REQ-024.
